seq_detector: RTL and testbench

Parametrised serial sequence detector: it samples a one-bit input `w` each enabled clock and asserts Moore output `z` for one cycle when the last `PAT_LEN` samples equal a run-time programmable pattern. It generalises the team's fixed two-state `w`/`z` FSM with programmable pattern length and content, overlap or non-overlap matching, an enable, a synchronous clear, and an optional saturating match counter. It sits between a serial bit source and any consumer of match events.

---
 rtl/seq_detector_pkg.sv | 18 +
 rtl/seq_detector_counter.sv | 36 +++
 rtl/seq_detector.sv | 113 +++++++++++
 tb/tb_seq_detector.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_detector_pkg.sv
// Shared types and helpers for the serial sequence detector.
//   state_e      : detector FSM states (history filling / history full)
//   PAT_LEN_MAX  : largest supported pattern length
//   fill_width() : bits needed to count 0..pat_len valid history bits
package seq_detector_pkg;

    localparam int unsigned PAT_LEN_MAX = 16;

    typedef enum logic {
        S_FILL  = 1'b0,
        S_ARMED = 1'b1
    } state_e;

    function automatic int unsigned fill_width(input int unsigned pat_len);
        return $clog2(pat_len + 1);
    endfunction

endpackage

// File: rtl/seq_detector_counter.sv
// Saturating match counter; sticks at all ones until clr or reset.
//   clk, rst_n : clock, async active-low reset
//   clr        : synchronous clear, priority over inc
//   inc        : count one event
//   count      : current count
//   sat        : high while count is all ones
module seq_detector_counter #(
    parameter int unsigned CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sat
);

    logic [CNT_W-1:0] count_inc_c;

    assign count_inc_c = count + CNT_W'(1);

    // sat is registered alongside count so it tracks the all-ones value exactly
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (clr) begin
            count <= '0;
            sat   <= 1'b0;
        end else if (inc && !sat) begin
            count <= count_inc_c;
            sat   <= &count_inc_c;
        end
    end

endmodule

// File: rtl/seq_detector.sv
// Programmable serial sequence detector with Moore match pulse.
// Optional feature macro: SEQ_DETECTOR_COUNT_EN (saturating match counter).
//   clk, rst_n  : clock, async active-low reset
//   en          : sample enable for w
//   clr         : synchronous clear of history, state, z and counter
//   w           : serial data bit
//   pattern     : target sequence, pattern[PAT_LEN-1] oldest bit
//   overlap     : 1 = overlapping matches, 0 = flush history after a match
//   z           : registered one-cycle match pulse
//   match_count : saturating match count (0 when counter not built)
//   count_sat   : high while match_count is all ones
module seq_detector
    import seq_detector_pkg::*;
#(
    parameter int unsigned PAT_LEN = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               clr,
    input  logic               w,
    input  logic [PAT_LEN-1:0] pattern,
    input  logic               overlap,
    output logic               z,
    output logic [CNT_W-1:0]   match_count,
    output logic               count_sat
);

    localparam int unsigned FILL_W = fill_width(PAT_LEN);

    if (PAT_LEN < 2 || PAT_LEN > PAT_LEN_MAX) begin : g_pat_len_check
        $error("seq_detector: PAT_LEN out of range 2..16");
    end

    state_e             state_q, state_d;
    logic [PAT_LEN-1:0] hist_q, hist_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               match_c;
    logic [PAT_LEN-1:0] hist_shift_c;
    logic               full_c;

    // State, history and fill registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            hist_q  <= '0;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            hist_q  <= hist_d;
            fill_q  <= fill_d;
        end
    end

    // Next state, next history and match decision
    always_comb begin
        state_d      = state_q;
        hist_d       = hist_q;
        fill_d       = fill_q;
        match_c      = 1'b0;
        hist_shift_c = {hist_q[PAT_LEN-2:0], w};
        // the sampled bit completes (or keeps) a full history
        full_c       = (state_q == S_ARMED) || (fill_q == FILL_W'(PAT_LEN - 1));

        if (clr) begin
            state_d = S_FILL;
            hist_d  = '0;
            fill_d  = '0;
        end else if (en) begin
            hist_d = hist_shift_c;
            if (full_c) begin
                state_d = S_ARMED;
                fill_d  = FILL_W'(PAT_LEN);
                match_c = (hist_shift_c == pattern);
            end else begin
                state_d = S_FILL;
                fill_d  = fill_q + FILL_W'(1);
            end
            // non-overlap: the matched bits may not start another match
            if (match_c && !overlap) begin
                state_d = S_FILL;
                fill_d  = '0;
            end
        end
    end

    // Moore match pulse, low on every edge without a match
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= 1'b0;
        end else begin
            z <= match_c;
        end
    end

`ifdef SEQ_DETECTOR_COUNT_EN
    seq_detector_counter #(
        .CNT_W (CNT_W)
    ) u_counter (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .inc   (match_c),
        .count (match_count),
        .sat   (count_sat)
    );
`else
    assign match_count = '0;
    assign count_sat   = 1'b0;
`endif

endmodule

// File: tb/tb_seq_detector.sv
// Bench for seq_detector: directed scenarios plus random stream, two
// configurations driven from the same serial inputs, checked against a
// queue-based model of the matching rules.
module tb_seq_detector;

`ifdef SEQ_DETECTOR_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    localparam int LA = 3;
    localparam int LB = 5;
    localparam int MAX_A = 3;    // 2-bit counter
    localparam int MAX_B = 255;  // 8-bit counter

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, clr, w, overlap;
    logic [2:0] pattern_a;
    logic [4:0] pattern_b;
    logic       z_a, z_b;
    logic [1:0] mc_a;
    logic [7:0] mc_b;
    logic       sat_a, sat_b;

    int total = 0;
    int bad   = 0;

    // model state: valid samples since last flush, match counts, expected z
    bit qa[$];
    bit qb[$];
    int cnt_a, cnt_b;
    bit za_exp, zb_exp;

    always #5 clk = ~clk;

    seq_detector #(.PAT_LEN(LA), .CNT_W(2)) dut_a (
        .clk (clk), .rst_n (rst_n), .en (en), .clr (clr), .w (w),
        .pattern (pattern_a), .overlap (overlap),
        .z (z_a), .match_count (mc_a), .count_sat (sat_a)
    );

    seq_detector #(.PAT_LEN(LB), .CNT_W(8)) dut_b (
        .clk (clk), .rst_n (rst_n), .en (en), .clr (clr), .w (w),
        .pattern (pattern_b), .overlap (overlap),
        .z (z_b), .match_count (mc_b), .count_sat (sat_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // last l samples, oldest first, compared against pat[l-1] .. pat[0]
    function automatic bit tail_match(input bit q[$], input int l, input logic [15:0] pat);
        if (q.size() != l) return 1'b0;
        for (int i = 0; i < l; i++) begin
            if (q[i] != pat[l-1-i]) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat_inc(input int c, input int cmax);
        return (c < cmax) ? c + 1 : c;
    endfunction

    task automatic model_clear();
        qa.delete();
        qb.delete();
        cnt_a  = 0;
        cnt_b  = 0;
        za_exp = 1'b0;
        zb_exp = 1'b0;
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, ".z_a"},   32'(z_a),   32'(za_exp));
        chk({tag, ".cnt_a"}, 32'(mc_a),  CNT_EN ? 32'(cnt_a) : 32'd0);
        chk({tag, ".sat_a"}, 32'(sat_a), 32'(CNT_EN && cnt_a == MAX_A));
        chk({tag, ".z_b"},   32'(z_b),   32'(zb_exp));
        chk({tag, ".cnt_b"}, 32'(mc_b),  CNT_EN ? 32'(cnt_b) : 32'd0);
        chk({tag, ".sat_b"}, 32'(sat_b), 32'(CNT_EN && cnt_b == MAX_B));
    endtask

    // One clock: drive at negedge, update model, check at following negedge
    task automatic step(input bit e, input bit c, input bit b);
        en  = e;
        clr = c;
        w   = b;
        if (c) begin
            model_clear();
        end else if (e) begin
            qa.push_back(b);
            if (qa.size() > LA) void'(qa.pop_front());
            za_exp = tail_match(qa, LA, 16'(pattern_a));
            if (za_exp) begin
                cnt_a = sat_inc(cnt_a, MAX_A);
                if (!overlap) qa.delete();
            end
            qb.push_back(b);
            if (qb.size() > LB) void'(qb.pop_front());
            zb_exp = tail_match(qb, LB, 16'(pattern_b));
            if (zb_exp) begin
                cnt_b = sat_inc(cnt_b, MAX_B);
                if (!overlap) qb.delete();
            end
        end else begin
            za_exp = 1'b0;
            zb_exp = 1'b0;
        end
        @(posedge clk);
        @(negedge clk);
        check_outputs("step");
    endtask

    // Asynchronous reset pulse taken between clock edges
    task automatic do_reset();
        en  = 1'b0;
        clr = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        model_clear();
        chk("rst.z_a",   32'(z_a),   32'd0);
        chk("rst.cnt_a", 32'(mc_a),  32'd0);
        chk("rst.sat_a", 32'(sat_a), 32'd0);
        chk("rst.z_b",   32'(z_b),   32'd0);
        chk("rst.cnt_b", 32'(mc_b),  32'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        bit s5[5];
        int zc;
        s5 = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};

        rst_n     = 1'b0;
        en        = 1'b0;
        clr       = 1'b0;
        w         = 1'b0;
        overlap   = 1'b1;
        pattern_a = 3'b101;
        pattern_b = 5'b10110;
        model_clear();
        repeat (2) @(negedge clk);
        check_outputs("reset");
        rst_n = 1'b1;

        // overlap, 1,0,1,0,1 -> pulses after samples 3 and 5
        overlap = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, s5[i]);
            if (i == 2) chk("ov.z3", 32'(z_a), 32'd1);
            if (i == 3) chk("ov.z4", 32'(z_a), 32'd0);
        end
        chk("ov.z5", 32'(z_a), 32'd1);
        chk("ov.count", 32'(mc_a), CNT_EN ? 32'd2 : 32'd0);

        // non-overlap, same stream -> single pulse
        overlap = 1'b0;
        step(1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, s5[i]);
            if (i == 2) chk("nov.z3", 32'(z_a), 32'd1);
        end
        chk("nov.z5", 32'(z_a), 32'd0);
        chk("nov.count", 32'(mc_a), CNT_EN ? 32'd1 : 32'd0);

        // enable gap
        overlap = 1'b1;
        step(1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0);
        chk("gap.z", 32'(z_a), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("gap.match", 32'(z_a), 32'd1);

        // saturation with pattern 111
        pattern_a = 3'b111;
        step(1'b0, 1'b1, 1'b0);
        zc = 0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b0, 1'b1);
            zc += int'(z_a);
        end
        chk("sat.zcycles", 32'(zc), 32'd4);
        chk("sat.count", 32'(mc_a), CNT_EN ? 32'd3 : 32'd0);
        chk("sat.flag", 32'(sat_a), 32'(CNT_EN));
        step(1'b0, 1'b1, 1'b0);
        chk("sat.clr_count", 32'(mc_a), 32'd0);
        chk("sat.clr_flag", 32'(sat_a), 32'd0);

        // clear mid-sequence discards partial history
        pattern_a = 3'b101;
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b1, 1'b1);
        step(1'b1, 1'b0, 1'b1);
        chk("clrmid.z1", 32'(z_a), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("clrmid.z2", 32'(z_a), 32'd0);
        step(1'b1, 1'b0, 1'b1);
        chk("clrmid.z3", 32'(z_a), 32'd1);

        // reset mid-sequence
        step(1'b1, 1'b0, 1'b1);
        step(1'b1, 1'b0, 1'b0);
        do_reset();
        step(1'b1, 1'b0, 1'b1);
        chk("rstmid.z1", 32'(z_a), 32'd0);
        step(1'b1, 1'b0, 1'b0);
        chk("rstmid.z2", 32'(z_a), 32'd0);

        // random stream; pattern/overlap change only on en=0 cycles
        for (int i = 0; i < 600; i++) begin
            if (i % 60 == 59) begin
                pattern_a = 3'($urandom);
                pattern_b = 5'($urandom);
                overlap   = 1'($urandom);
                step(1'b0, 1'b0, 1'($urandom));
            end else if ($urandom_range(0, 149) == 0) begin
                do_reset();
            end else begin
                step($urandom_range(0, 9) != 0, $urandom_range(0, 79) == 0, 1'($urandom));
            end
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
